// File: rtl/fpu_link_pkg.sv
// Shared types and constants for the host side of the 12-bit chip pin protocol.
package fpu_link_pkg;

  localparam int DATA_W_DEF = 10;
  localparam int OP_W_DEF   = 4;

  localparam logic [1:0] TAG_IDLE = 2'b00;
  localparam logic [1:0] TAG_A    = 2'b01;
  localparam logic [1:0] TAG_B    = 2'b10;
  localparam logic [1:0] TAG_OP   = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    SEND_A,
    SEND_B,
    SEND_OP,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/fpu_link_beat_mux.sv
// Registered chip_in beat generator; fed the next state so the beat lines up
// with the state register (A beat appears the cycle after request acceptance).
module fpu_link_beat_mux
  import fpu_link_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OP_W   = OP_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  state_t            state_nxt,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   op,
  output logic [DATA_W+1:0] chip_in
);

  logic [DATA_W+1:0] beat;

  always_comb begin
    beat = {{DATA_W{1'b0}}, TAG_IDLE};
    case (state_nxt)
      SEND_A:  beat = {a, TAG_A};
      SEND_B:  beat = {b, TAG_B};
      SEND_OP: beat = {{(DATA_W-OP_W){1'b0}}, op, TAG_OP};
      default: beat = {{DATA_W{1'b0}}, TAG_IDLE};
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) chip_in <= '0;
    else       chip_in <= beat;
  end

endmodule

// File: rtl/fpu_link_host.sv
// Host endpoint: serialises one (a, b, op) request into three pin beats, waits for
// the chip's done strobe (or a timeout) and returns the result over valid/ready.
module fpu_link_host
  import fpu_link_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int OP_W    = OP_W_DEF,
  parameter int TIMEOUT = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [OP_W-1:0]   req_op,
  output logic [DATA_W+1:0] chip_in,
  input  logic [DATA_W+1:0] chip_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_y,
  output logic              rsp_timeout,
  output logic              busy
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  state_t            state, state_nxt;
  logic [DATA_W-1:0] a_q, b_q, a_d, b_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic              done_q;
  logic [DATA_W-1:0] y_q;
  logic [CNT_W-1:0]  cnt;
  logic              accept;
  logic              unused_bit;

  assign unused_bit = chip_out[1];
  assign accept     = (state == IDLE) && req_valid;
  assign a_d        = accept ? req_a  : a_q;
  assign b_d        = accept ? req_b  : b_q;
  assign op_d       = accept ? req_op : op_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Done from the registered pin copy wins over a timeout landing in the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = SEND_A;
      SEND_A:  state_nxt = SEND_B;
      SEND_B:  state_nxt = SEND_OP;
      SEND_OP: state_nxt = WAIT;
      WAIT:    if (done_q || (cnt == LIMIT)) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE) && !reset;
    busy      = (state != IDLE);
    rsp_valid = (state == RESP);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      done_q      <= 1'b0;
      y_q         <= '0;
      cnt         <= '0;
      rsp_y       <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      op_q   <= op_d;
      done_q <= chip_out[0];
      y_q    <= chip_out[DATA_W+1:2];
      cnt    <= (state == WAIT) ? cnt + CNT_W'(1) : '0;
      if (state == WAIT) begin
        if (done_q) begin
          rsp_y       <= y_q;
          rsp_timeout <= 1'b0;
        end else if (cnt == LIMIT) begin
          rsp_y       <= '0;
          rsp_timeout <= 1'b1;
        end
      end
    end
  end

  fpu_link_beat_mux #(
    .DATA_W (DATA_W),
    .OP_W   (OP_W)
  ) u_beat_mux (
    .clock     (clock),
    .reset     (reset),
    .state_nxt (state_nxt),
    .a         (a_d),
    .b         (b_d),
    .op        (op_d),
    .chip_in   (chip_in)
  );

endmodule

// File: tb/tb_fpu_link_host.sv
// Directed bench for fpu_link_host: beats, response path, backpressure, timeout, reset.
module tb_fpu_link_host;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [9:0]  req_a = '0;
  logic [9:0]  req_b = '0;
  logic [3:0]  req_op = '0;
  logic [11:0] chip_in;
  logic [11:0] chip_out = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [9:0]  rsp_y;
  logic        rsp_timeout;
  logic        busy;

  int checks = 0;
  int errors = 0;

  fpu_link_host #(.DATA_W(10), .OP_W(4), .TIMEOUT(64)) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_op      (req_op),
    .chip_in     (chip_in),
    .chip_out    (chip_out),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_y       (rsp_y),
    .rsp_timeout (rsp_timeout),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(negedge clock);
  endtask

  // Leaves the bench in the first SEND_A cycle.
  task automatic issue(input logic [9:0] a, input logic [9:0] b, input logic [3:0] op);
    req_a = a; req_b = b; req_op = op; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic grab_beats(output logic [11:0] c0, output logic [11:0] c1,
                            output logic [11:0] c2, output logic [11:0] c3);
    c0 = chip_in; tick();
    c1 = chip_in; tick();
    c2 = chip_in; tick();
    c3 = chip_in;
  endtask

  task automatic pulse_done(input logic [9:0] y);
    chip_out = {y, 2'b01};
    tick();
    chip_out = '0;
  endtask

  task automatic wait_rsp(input int limit, output int n);
    n = 0;
    while (rsp_valid !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    tick(); tick();
    checks++; if (chip_in !== 12'h000) begin errors++; $display("FAIL reset_chip_in got %h want 000", chip_in); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    checks++; if ({rsp_y, rsp_timeout} !== 11'h000) begin errors++; $display("FAIL reset_rsp got y=%h to=%b want 0/0", rsp_y, rsp_timeout); end
    reset = 1'b0;
    tick();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
  endtask

  task automatic test_basic();
    logic [11:0] c0, c1, c2, c3;
    int n;
    issue(10'h155, 10'h0AA, 4'h3);
    grab_beats(c0, c1, c2, c3);
    checks++; if (c0 !== 12'h555) begin errors++; $display("FAIL basic_a_beat got %h want 555", c0); end
    checks++; if (c1 !== 12'h2AA) begin errors++; $display("FAIL basic_b_beat got %h want 2aa", c1); end
    checks++; if (c2 !== 12'h00F) begin errors++; $display("FAIL basic_op_beat got %h want 00f", c2); end
    checks++; if ({c3, busy, req_ready} !== {12'h000, 1'b1, 1'b0}) begin errors++; $display("FAIL basic_wait got chip_in=%h busy=%b rdy=%b want 000/1/0", c3, busy, req_ready); end
    repeat (4) tick();
    pulse_done(10'h1FF);
    wait_rsp(20, n);
    checks++; if (n !== 1) begin errors++; $display("FAIL basic_done_latency got %0d want 1", n); end
    checks++; if ({rsp_valid, rsp_y, rsp_timeout} !== {1'b1, 10'h1FF, 1'b0}) begin errors++; $display("FAIL basic_rsp got v=%b y=%h to=%b want 1/1ff/0", rsp_valid, rsp_y, rsp_timeout); end
    finish_rsp();
    checks++; if ({rsp_valid, req_ready, busy} !== 3'b010) begin errors++; $display("FAIL basic_idle got v=%b rdy=%b busy=%b want 0/1/0", rsp_valid, req_ready, busy); end
  endtask

  task automatic test_backpressure();
    logic [11:0] c0, c1, c2, c3;
    int n, bad;
    issue(10'h3C3, 10'h00F, 4'h5);
    grab_beats(c0, c1, c2, c3);
    checks++; if ({c0, c1, c2, c3} !== {12'hF0D, 12'h03E, 12'h017, 12'h000}) begin errors++; $display("FAIL bp_beats got %h %h %h %h want f0d 03e 017 000", c0, c1, c2, c3); end
    pulse_done(10'h2B5);
    wait_rsp(20, n);
    checks++; if ({rsp_valid, rsp_y} !== {1'b1, 10'h2B5}) begin errors++; $display("FAIL bp_rsp got v=%b y=%h want 1/2b5", rsp_valid, rsp_y); end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rsp_valid !== 1'b1 || rsp_y !== 10'h2B5 || rsp_timeout !== 1'b0 || req_ready !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold got %0d unstable cycles want 0", bad); end
    finish_rsp();
    checks++; if ({rsp_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL bp_release got v=%b rdy=%b want 0/1", rsp_valid, req_ready); end
  endtask

  task automatic test_timeout();
    logic [11:0] c0, c1, c2, c3;
    int n;
    chip_out = '0;
    issue(10'h001, 10'h002, 4'h4);
    grab_beats(c0, c1, c2, c3);
    wait_rsp(100, n);
    checks++; if (n !== 64) begin errors++; $display("FAIL timeout_cycles got %0d want 64", n); end
    checks++; if ({rsp_valid, rsp_timeout, rsp_y} !== {1'b1, 1'b1, 10'h000}) begin errors++; $display("FAIL timeout_rsp got v=%b to=%b y=%h want 1/1/000", rsp_valid, rsp_timeout, rsp_y); end
    finish_rsp();
  endtask

  task automatic test_done_at_limit();
    logic [11:0] c0, c1, c2, c3;
    int n;
    issue(10'h111, 10'h222, 4'h6);
    grab_beats(c0, c1, c2, c3);
    repeat (62) tick();
    pulse_done(10'h0C3);
    wait_rsp(5, n);
    checks++; if (n !== 1) begin errors++; $display("FAIL limit_latency got %0d want 1", n); end
    checks++; if ({rsp_valid, rsp_timeout, rsp_y} !== {1'b1, 1'b0, 10'h0C3}) begin errors++; $display("FAIL limit_done_wins got v=%b to=%b y=%h want 1/0/0c3", rsp_valid, rsp_timeout, rsp_y); end
    finish_rsp();
  endtask

  task automatic test_stray_done();
    logic [11:0] c0, c1, c2, c3;
    int n, bad;
    pulse_done(10'h3FF);
    tick(); tick();
    checks++; if ({rsp_valid, busy} !== 2'b00) begin errors++; $display("FAIL stray_idle got v=%b busy=%b want 0/0", rsp_valid, busy); end
    issue(10'h0F0, 10'h10F, 4'h9);
    c0 = chip_in; tick();
    c1 = chip_in;
    chip_out = {10'h3FF, 2'b01};
    tick();
    chip_out = '0;
    c2 = chip_in; tick();
    c3 = chip_in;
    checks++; if ({c0, c1, c2, c3} !== {12'h3C1, 12'h43E, 12'h027, 12'h000}) begin errors++; $display("FAIL stray_beats got %h %h %h %h want 3c1 43e 027 000", c0, c1, c2, c3); end
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid !== 1'b0 || busy !== 1'b1) bad++;
      tick();
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL stray_ignored got %0d bad cycles want 0", bad); end
    pulse_done(10'h123);
    wait_rsp(5, n);
    checks++; if ({rsp_valid, rsp_y, rsp_timeout} !== {1'b1, 10'h123, 1'b0}) begin errors++; $display("FAIL stray_real_rsp got v=%b y=%h to=%b want 1/123/0", rsp_valid, rsp_y, rsp_timeout); end
    finish_rsp();
  endtask

  task automatic test_reset_midop();
    logic [11:0] c0, c1, c2, c3;
    int n;
    issue(10'h2AA, 10'h155, 4'hC);
    tick();
    checks++; if (chip_in !== 12'h556) begin errors++; $display("FAIL midop_b_beat got %h want 556", chip_in); end
    reset = 1'b1;
    #1;
    checks++; if ({chip_in, busy, rsp_valid} !== {12'h000, 1'b0, 1'b0}) begin errors++; $display("FAIL midop_reset got chip_in=%h busy=%b v=%b want 000/0/0", chip_in, busy, rsp_valid); end
    tick();
    reset = 1'b0;
    tick();
    checks++; if ({chip_in, busy, req_ready} !== {12'h000, 1'b0, 1'b1}) begin errors++; $display("FAIL midop_release got chip_in=%h busy=%b rdy=%b want 000/0/1", chip_in, busy, req_ready); end
    issue(10'h001, 10'h3FF, 4'hF);
    grab_beats(c0, c1, c2, c3);
    checks++; if ({c0, c1, c2, c3} !== {12'h005, 12'hFFE, 12'h03F, 12'h000}) begin errors++; $display("FAIL midop_new_beats got %h %h %h %h want 005 ffe 03f 000", c0, c1, c2, c3); end
    tick();
    pulse_done(10'h077);
    wait_rsp(5, n);
    checks++; if ({rsp_valid, rsp_y} !== {1'b1, 10'h077}) begin errors++; $display("FAIL midop_rsp got v=%b y=%h want 1/077", rsp_valid, rsp_y); end
    finish_rsp();
  endtask

  task automatic test_back_to_back();
    logic [11:0] c0, c1, c2, c3;
    int n, bad;
    req_a = 10'h0A5; req_b = 10'h35A; req_op = 4'h1; req_valid = 1'b1;
    tick();
    c0 = chip_in;
    req_a = 10'h200; req_b = 10'h001; req_op = 4'hE;
    tick(); c1 = chip_in;
    tick(); c2 = chip_in;
    tick(); c3 = chip_in;
    checks++; if ({c0, c1, c2, c3} !== {12'h295, 12'hD6A, 12'h007, 12'h000}) begin errors++; $display("FAIL b2b_first_beats got %h %h %h %h want 295 d6a 007 000", c0, c1, c2, c3); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_busy_ready got %b want 0", req_ready); end
    pulse_done(10'h0AB);
    wait_rsp(5, n);
    checks++; if ({rsp_valid, rsp_y} !== {1'b1, 10'h0AB}) begin errors++; $display("FAIL b2b_first_rsp got v=%b y=%h want 1/0ab", rsp_valid, rsp_y); end
    bad = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || chip_in !== 12'h000) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL b2b_no_early_accept got %0d bad cycles want 0", bad); end
    finish_rsp();
    checks++; if ({rsp_valid, req_ready, chip_in} !== {1'b0, 1'b1, 12'h000}) begin errors++; $display("FAIL b2b_gap got v=%b rdy=%b chip_in=%h want 0/1/000", rsp_valid, req_ready, chip_in); end
    tick();
    req_valid = 1'b0;
    grab_beats(c0, c1, c2, c3);
    checks++; if ({c0, c1, c2, c3} !== {12'h801, 12'h006, 12'h03B, 12'h000}) begin errors++; $display("FAIL b2b_second_beats got %h %h %h %h want 801 006 03b 000", c0, c1, c2, c3); end
    pulse_done(10'h0CD);
    wait_rsp(5, n);
    checks++; if ({rsp_valid, rsp_y, rsp_timeout} !== {1'b1, 10'h0CD, 1'b0}) begin errors++; $display("FAIL b2b_second_rsp got v=%b y=%h to=%b want 1/0cd/0", rsp_valid, rsp_y, rsp_timeout); end
    finish_rsp();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_timeout();
    test_done_at_limit();
    test_stray_done();
    test_reset_midop();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
